result_drain: RTL and testbench

- Downstream stage of the matrix-multiply controller.
- After the multiply reports done, it reads the 1024x21 result memory (C) in address order and streams each word out on a valid/ready interface.
- It owns the C-memory port only while draining; the multiply controller owns it otherwise.
- Memory read latency is one clock (synchronous macro), hidden by a 2-entry output buffer.

---
 rtl/result_drain.sv | 90 +++++++++
 tb/tb_result_drain.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/result_drain.sv
// result_drain: streams the C result memory out over valid/ready once the multiply reports done.
// Ports: clk; rst (async, active-low); start pulse -> busy until last accept, drain_done pulse;
// mem_addr/mem_nce/mem_wen/mem_do drive the C-memory read port (1-cycle read latency);
// out_data/out_valid/out_ready/out_last form the output stream.
// Optional: define RESULT_DRAIN_CHECKSUM_EN to add checksum[31:0], the sum of all streamed words.
module result_drain #(
  parameter int DW = 21,
  parameter int AW = 10,
  parameter int N_WORDS = 1024
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          drain_done,
  output logic [AW-1:0] mem_addr,
  output logic          mem_nce,
  output logic          mem_wen,
  input  logic [DW-1:0] mem_do,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_last
`ifdef RESULT_DRAIN_CHECKSUM_EN
  ,
  output logic [31:0]   checksum
`endif
);
  localparam logic [1:0] IDLE = 2'd0, STREAM = 2'd1, DONE = 2'd2;
  localparam logic [AW:0] END_A = (AW+1)'(N_WORDS);
  localparam logic [AW:0] LAST_A = (AW+1)'(N_WORDS - 1);
  logic [1:0] state, occ, wr_idx;
  logic [AW:0] rd_addr;
  logic in_flight, in_flight_last, go, pop, issue;
  logic [DW-1:0] d0, d1;
  logic l0, l1;
  // the read is issued in the start cycle itself so the first word is visible two cycles later;
  // the word leaving the buffer this cycle frees its slot, which keeps the stream bubble-free
  assign go = state == IDLE && start;
  assign pop = out_valid && out_ready;
  assign issue = (go || state == STREAM) && rd_addr != END_A &&
                 ({1'b0, occ} + {2'b0, in_flight} - {2'b0, pop}) < 3'd2;
  assign wr_idx = occ - {1'b0, pop};
  assign mem_nce = !issue;
  assign mem_wen = 1'b1;
  assign mem_addr = rd_addr[AW-1:0];
  assign busy = state == STREAM;
  assign drain_done = state == DONE;
  assign out_valid = occ != 2'd0;
  assign out_data = d0;
  assign out_last = l0 && out_valid;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      rd_addr <= '0;
      in_flight <= 1'b0;
      in_flight_last <= 1'b0;
      occ <= 2'd0;
      d0 <= '0;
      d1 <= '0;
      l0 <= 1'b0;
      l1 <= 1'b0;
    end else begin
      in_flight <= issue;
      in_flight_last <= issue && rd_addr == LAST_A;
      rd_addr <= state == DONE ? '0 : rd_addr + (AW+1)'(issue);
      state <= go ? STREAM : (state == STREAM && pop && l0) ? DONE : state == DONE ? IDLE : state;
      occ <= occ + {1'b0, in_flight} - {1'b0, pop};
      if (pop) begin
        d0 <= d1;
        l0 <= l1;
      end
      if (in_flight && wr_idx == 2'd0) begin
        d0 <= mem_do;
        l0 <= in_flight_last;
      end
      if (in_flight && wr_idx == 2'd1) begin
        d1 <= mem_do;
        l1 <= in_flight_last;
      end
    end
  end
`ifdef RESULT_DRAIN_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) checksum <= '0;
    else if (go) checksum <= '0;
    else if (pop) checksum <= checksum + 32'(out_data);
  end
`endif
endmodule

// File: tb/tb_result_drain.sv
// tb_result_drain: directed bench for result_drain with a word-sequence model and per-cycle compare.
module tb_result_drain;
  localparam int DW = 21, AW = 10, N = 1024;
  logic clk = 0, rst = 0, start = 0, out_ready = 0;
  logic busy, drain_done, mem_nce, mem_wen, out_valid, out_last;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_do = '0, out_data;
`ifdef RESULT_DRAIN_CHECKSUM_EN
  logic [31:0] checksum;
`endif
  result_drain #(.DW(DW), .AW(AW), .N_WORDS(N)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .drain_done(drain_done),
    .mem_addr(mem_addr), .mem_nce(mem_nce), .mem_wen(mem_wen), .mem_do(mem_do),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last)
`ifdef RESULT_DRAIN_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );
  always #5 clk = ~clk;
  logic [DW-1:0] mem [N];
  always @(posedge clk) if (!mem_nce) mem_do <= mem[mem_addr];
  int n_cmp = 0, n_err = 0;
  task automatic chk(string name, longint act, longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask
  int mode = 1;
  initial forever begin
    @(posedge clk);
    #1;
    out_ready = mode == 0 ? 1'b0 : mode == 1 ? 1'b1 : 1'($urandom % 2);
  end
  int cyc = 0, exp_idx = 0, issued = 0, done_cnt = 0;
  int start_cyc = 0, first_valid_cyc = 0, last_hs_cyc = 0;
  longint first_data = -1;
  bit run_active = 0, done_exp = 0, seen_valid = 0, hold_v = 0, hold_l = 0, pop;
  logic [DW-1:0] hold_d;
  logic [31:0] sum_m = 0;
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      run_active = 0;
      done_exp = 0;
      hold_v = 0;
      sum_m = 0;
    end else begin
      pop = out_valid && out_ready;
      chk("busy", busy, run_active);
      chk("drain_done", drain_done, done_exp);
      if (done_exp) begin
        done_cnt++;
`ifdef RESULT_DRAIN_CHECKSUM_EN
        chk("checksum_model", checksum, sum_m);
`endif
      end
      if (hold_v) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, hold_d);
        chk("stall_last", out_last, hold_l);
      end
      if (!out_valid) chk("last_without_valid", out_last, 0);
      if (!run_active && !done_exp && start) begin
        run_active = 1;
        exp_idx = 0;
        issued = 0;
        start_cyc = cyc;
        seen_valid = 0;
        sum_m = 0;
      end
      done_exp = 0;
      if (!mem_nce) begin
        chk("issue_in_run", run_active, 1);
        chk("read_addr", mem_addr, issued);
        chk("read_room", (issued - exp_idx - int'(pop)) < 2, 1);
        issued++;
      end
      if (run_active && out_valid && !seen_valid) begin
        seen_valid = 1;
        first_valid_cyc = cyc;
      end
      if (pop) begin
        chk("accept_in_run", run_active, 1);
        if (run_active) begin
          chk("word_data", out_data, mem[exp_idx]);
          chk("word_last", out_last, exp_idx == N - 1);
          if (exp_idx == 0) first_data = out_data;
          sum_m += 32'(out_data);
          if (exp_idx == N - 1) begin
            run_active = 0;
            done_exp = 1;
            last_hs_cyc = cyc;
          end
          exp_idx++;
        end
      end
      hold_v = out_valid && !out_ready;
      hold_d = out_data;
      hold_l = out_last;
    end
  end
  task automatic pulse_start();
    @(posedge clk);
    #1 start = 1;
    @(posedge clk);
    #1 start = 0;
  endtask
  task automatic wait_done(int budget);
    int k = 0;
    while (!drain_done && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("done_reached", drain_done, 1);
    repeat (3) @(negedge clk);
  endtask
  task automatic wait_idx(int target);
    int k = 0;
    while (exp_idx < target && k < 5000) begin
      @(negedge clk);
      k++;
    end
    chk("index_reached", exp_idx >= target, 1);
  endtask
  task automatic chk_reset_outputs(string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_drain_done"}, drain_done, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_last"}, out_last, 0);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_mem_nce"}, mem_nce, 1);
    chk({tag, "_mem_addr"}, mem_addr, 0);
  endtask
  initial begin
    int d;
    for (int i = 0; i < N; i++) mem[i] = DW'(i * 3);
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    chk("mem_wen", mem_wen, 1);
    @(posedge clk);
    #1 rst = 1;
    mode = 1;
    pulse_start();
    wait_done(3000);
    chk("first_valid_latency", first_valid_cyc - start_cyc, 2);
    chk("no_bubbles", last_hs_cyc - first_valid_cyc, N - 1);
    chk("words_run1", exp_idx, N);
    chk("last_word_value", mem[N-1], 3069);
    mode = 2;
    pulse_start();
    wait_done(8000);
    chk("words_random", exp_idx, N);
    mode = 0;
    pulse_start();
    repeat (20) @(negedge clk);
    chk("stall_reads", issued, 2);
    chk("stall_nce", mem_nce, 1);
    chk("stall_head", out_data, 0);
    mode = 1;
    wait_done(3000);
    chk("words_stall", exp_idx, N);
    d = done_cnt;
    pulse_start();
    wait_idx(100);
    pulse_start();
    wait_done(3000);
    chk("single_done", done_cnt - d, 1);
    chk("words_restart_ignored", exp_idx, N);
    mode = 2;
    pulse_start();
    wait_idx(500);
    @(posedge clk);
    #1 rst = 0;
    #1 chk_reset_outputs("midrun");
    @(posedge clk);
    #1 rst = 1;
    first_data = -1;
    mode = 1;
    pulse_start();
    wait_done(3000);
    chk("restart_first_word", first_data, 0);
    chk("words_after_reset", exp_idx, N);
`ifdef RESULT_DRAIN_CHECKSUM_EN
    for (int i = 0; i < N; i++) mem[i] = DW'(i);
    for (int r = 0; r < 2; r++) begin
      pulse_start();
      wait_done(3000);
      chk("checksum_literal", checksum, 523776);
      repeat (4) @(negedge clk);
      chk("checksum_stable", checksum, 523776);
    end
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
